harmonic_sequencer: RTL and testbench

- Parametrised frame sequencer for the additive oscillator. Once per sample period it walks harmonics 0..limit-1 and, for each harmonic, handshakes with the sample-position, scale-multiplier and adder blocks.
- Routes each harmonic to one of NUM_CHANNELS accumulators, latches the channel totals and triggers the DAC output block.
- Additions over the previous hard-wired sequencer: N channels, runtime harmonic limit, comb-mute skipping, and overrun abort with a counter.

---
 rtl/harmonic_sequencer_pkg.sv | 24 ++
 rtl/sample_tick_timer.sv | 35 +++
 rtl/harmonic_sequencer.sv | 160 ++++++++++++++++
 tb/tb_harmonic_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harmonic_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : harmonic_sequencer_pkg
// Shared state encoding and timing constants for the harmonic sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package harmonic_sequencer_pkg;

  localparam int C_CLOCK_HZ        = 48_000_000;
  localparam int C_SAMPLE_RATE_HZ  = 48_000;
  localparam int C_SAMPLE_INTERVAL = C_CLOCK_HZ / C_SAMPLE_RATE_HZ;
  localparam int C_NUM_HARMONICS   = 64;

  localparam int C_STATE_W = 3;
  localparam logic [C_STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [C_STATE_W-1:0] ST_MULT      = 3'd1;
  localparam logic [C_STATE_W-1:0] ST_MULT_WAIT = 3'd2;
  localparam logic [C_STATE_W-1:0] ST_ADD_WAIT  = 3'd3;
  localparam logic [C_STATE_W-1:0] ST_NEXT      = 3'd4;
  localparam logic [C_STATE_W-1:0] ST_DONE      = 3'd5;
  localparam logic [C_STATE_W-1:0] ST_WAIT_TICK = 3'd6;

endpackage
`default_nettype wire

// File: rtl/sample_tick_timer.sv
`default_nettype none
// ============================================================================
// Module : sample_tick_timer
// Free-running 0..SAMPLE_INTERVAL-1 counter with a one-cycle tick on the last count.
// Rev    : 1.0  initial release
// ============================================================================
module sample_tick_timer
  import harmonic_sequencer_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = C_SAMPLE_INTERVAL
) (
  input  logic i_Clock,
  input  logic reset_n,
  output logic o_Tick
);

  localparam int CNT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SAMPLE_INTERVAL - 1);

  logic [CNT_W-1:0] r_count;

  assign o_Tick = (r_count == C_LAST);

  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (o_Tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/harmonic_sequencer.sv
`default_nettype none
// ============================================================================
// Module : harmonic_sequencer
// Per-sample frame sequencer: walks harmonics, routes them to N adders, sends totals to the DAC.
// Rev    : 1.0  initial release
// ============================================================================
module harmonic_sequencer
  import harmonic_sequencer_pkg::*;
#(
  parameter int NUM_HARMONICS   = C_NUM_HARMONICS,
  parameter int NUM_CHANNELS    = 2,
  parameter int SAMPLE_INTERVAL = C_SAMPLE_INTERVAL,
  parameter int HARM_W          = 8,
  parameter int ACC_W           = 32
) (
  input  logic                           i_Clock,
  input  logic                           reset_n,
  input  logic                           i_Enable,
  input  logic [HARM_W-1:0]              i_Harmonic_Limit,
  output logic [HARM_W-1:0]              o_Harmonic,
  output logic                           o_Next_Sample,
  input  logic                           i_Sample_Ready,
  input  logic                           i_Freq_Too_High,
  output logic                           o_Mult_Start,
  output logic                           o_Mult_Restart,
  input  logic                           i_Mult_Ready,
  input  logic                           i_Comb_Muted,
  output logic [NUM_CHANNELS-1:0]        o_Adder_Start,
  output logic                           o_Adder_Clear,
  input  logic [NUM_CHANNELS*ACC_W-1:0]  i_Adder_Total,
  output logic [NUM_CHANNELS*ACC_W-1:0]  o_Channel_Total,
  output logic                           o_DAC_Send,
  output logic [7:0]                     o_Overrun_Count,
  output logic                           o_Busy
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CHANNELS - 1);

  logic [C_STATE_W-1:0]    r_state;
  logic [HARM_W-1:0]       r_last;
  logic [CH_W-1:0]         r_channel;
  logic [HARM_W-1:0]       w_last;
  logic [NUM_CHANNELS-1:0] w_chan_sel;
  logic                    w_tick;
  logic                    w_in_frame;
  logic                    w_abort;

  sample_tick_timer #(
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
  ) u_tick_timer (
    .i_Clock (i_Clock),
    .reset_n (reset_n),
    .o_Tick  (w_tick)
  );

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan_sel
    assign w_chan_sel[c] = (r_channel == CH_W'(c));
  end

  // Index of the last harmonic in the frame: limit clamped to 1..NUM_HARMONICS, minus one.
  always_comb begin
    w_last = '0;
    if (32'(i_Harmonic_Limit) > NUM_HARMONICS) begin
      w_last = HARM_W'(NUM_HARMONICS - 1);
    end else if (i_Harmonic_Limit != '0) begin
      w_last = i_Harmonic_Limit - HARM_W'(1);
    end
  end

  assign w_in_frame = (r_state == ST_MULT) || (r_state == ST_MULT_WAIT) ||
                      (r_state == ST_ADD_WAIT) || (r_state == ST_NEXT);
  assign w_abort    = w_tick && w_in_frame;
  assign o_Busy     = (r_state != ST_IDLE) && (r_state != ST_WAIT_TICK);

  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_last          <= '0;
      r_channel       <= '0;
      o_Harmonic      <= '0;
      o_Next_Sample   <= 1'b0;
      o_Mult_Start    <= 1'b0;
      o_Mult_Restart  <= 1'b0;
      o_Adder_Start   <= '0;
      o_Adder_Clear   <= 1'b0;
      o_Channel_Total <= '0;
      o_DAC_Send      <= 1'b0;
      o_Overrun_Count <= '0;
    end else begin
      o_Next_Sample  <= 1'b0;
      o_Mult_Start   <= 1'b0;
      o_Mult_Restart <= 1'b0;
      o_Adder_Start  <= '0;
      o_Adder_Clear  <= 1'b0;
      o_DAC_Send     <= 1'b0;
      // A tick mid-frame wins over any handshake: ship the partial totals and restart.
      if (w_abort) begin
        o_Channel_Total <= i_Adder_Total;
        o_Adder_Clear   <= 1'b1;
        o_DAC_Send      <= 1'b1;
        if (o_Overrun_Count != 8'hFF) begin
          o_Overrun_Count <= o_Overrun_Count + 8'd1;
        end
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_Enable) begin
              o_Mult_Restart <= 1'b1;
              o_Harmonic     <= '0;
              r_channel      <= '0;
              r_last         <= w_last;
              r_state        <= ST_ADD_WAIT;
            end
          end
          ST_MULT: begin
            o_Mult_Start <= 1'b1;
            r_state      <= ST_MULT_WAIT;
          end
          ST_MULT_WAIT: begin
            if (i_Mult_Ready) begin
              r_state <= i_Comb_Muted ? ST_NEXT : ST_ADD_WAIT;
            end
          end
          ST_ADD_WAIT: begin
            if (i_Sample_Ready) begin
              o_Adder_Start <= w_chan_sel;
              r_state       <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if ((o_Harmonic >= r_last) || i_Freq_Too_High) begin
              r_state <= ST_DONE;
            end else begin
              o_Harmonic    <= o_Harmonic + HARM_W'(1);
              r_channel     <= (r_channel == C_LAST_CH) ? '0 : r_channel + CH_W'(1);
              o_Next_Sample <= 1'b1;
              r_state       <= ST_MULT;
            end
          end
          ST_DONE: begin
            o_Channel_Total <= i_Adder_Total;
            o_Adder_Clear   <= 1'b1;
            r_state         <= ST_WAIT_TICK;
          end
          ST_WAIT_TICK: begin
            if (w_tick) begin
              o_DAC_Send <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_harmonic_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_harmonic_sequencer
// Scoreboard bench: two sequencers (2 and 3 channels) driven by the same handshakes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_harmonic_sequencer;

  localparam int SI = 400;
  localparam int NH = 64;

  typedef struct {
    int         h;
    logic [1:0] a;
    logic [2:0] b;
  } exp_start_t;

  typedef struct {
    logic [31:0] ta;
    logic [47:0] tb;
    logic [7:0]  ovr;
  } exp_send_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_Enable = 1'b0;
  logic [7:0]  i_Harmonic_Limit = '0;
  logic        i_Sample_Ready = 1'b1;
  logic        i_Freq_Too_High = 1'b0;
  logic        i_Mult_Ready = 1'b1;
  logic        i_Comb_Muted = 1'b0;
  logic [31:0] tot_a = '0;
  logic [47:0] tot_b = '0;

  logic [7:0]  a_harm, b_harm, a_ovr, b_ovr;
  logic        a_next, a_mstart, a_mrestart, a_clear, a_send, a_busy;
  logic        b_next, b_mstart, b_mrestart, b_clear, b_send, b_busy;
  logic [1:0]  a_astart;
  logic [2:0]  b_astart;
  logic [31:0] a_total;
  logic [47:0] b_total;

  exp_start_t sb_q[$];
  exp_send_t  sd_q[$];
  int         nchecks = 0;
  int         nerr = 0;
  int         edges = 0;
  logic [7:0] exp_ovr = '0;

  always #5 clk = ~clk;

  harmonic_sequencer #(
    .NUM_HARMONICS(NH), .NUM_CHANNELS(2), .SAMPLE_INTERVAL(SI), .HARM_W(8), .ACC_W(16)
  ) dut_a (
    .i_Clock(clk), .reset_n(reset_n), .i_Enable(i_Enable), .i_Harmonic_Limit(i_Harmonic_Limit),
    .o_Harmonic(a_harm), .o_Next_Sample(a_next), .i_Sample_Ready(i_Sample_Ready),
    .i_Freq_Too_High(i_Freq_Too_High), .o_Mult_Start(a_mstart), .o_Mult_Restart(a_mrestart),
    .i_Mult_Ready(i_Mult_Ready), .i_Comb_Muted(i_Comb_Muted), .o_Adder_Start(a_astart),
    .o_Adder_Clear(a_clear), .i_Adder_Total(tot_a), .o_Channel_Total(a_total),
    .o_DAC_Send(a_send), .o_Overrun_Count(a_ovr), .o_Busy(a_busy)
  );

  harmonic_sequencer #(
    .NUM_HARMONICS(NH), .NUM_CHANNELS(3), .SAMPLE_INTERVAL(SI), .HARM_W(8), .ACC_W(16)
  ) dut_b (
    .i_Clock(clk), .reset_n(reset_n), .i_Enable(i_Enable), .i_Harmonic_Limit(i_Harmonic_Limit),
    .o_Harmonic(b_harm), .o_Next_Sample(b_next), .i_Sample_Ready(i_Sample_Ready),
    .i_Freq_Too_High(i_Freq_Too_High), .o_Mult_Start(b_mstart), .o_Mult_Restart(b_mrestart),
    .i_Mult_Ready(i_Mult_Ready), .i_Comb_Muted(i_Comb_Muted), .o_Adder_Start(b_astart),
    .o_Adder_Clear(b_clear), .i_Adder_Total(tot_b), .o_Channel_Total(b_total),
    .o_DAC_Send(b_send), .o_Overrun_Count(b_ovr), .o_Busy(b_busy)
  );

  task automatic align_to_period();
    while ((edges % SI) != 0) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Runs one frame; fth < 0 disables the Nyquist stop, stall_h < 0 disables the sample stall.
  task automatic run_frame(input string name, input int limit, input logic [63:0] mute,
                           input int fth, input int stall_h);
    int         last, lat, cyc, restart_at, nclear, nrestart, nsend, nnext, nmstart;
    exp_start_t e;
    exp_send_t  s;
    exp_start_t g;
    exp_send_t  gs;
    last = (limit < 1) ? 0 : ((limit > NH) ? NH - 1 : limit - 1);
    if (fth >= 0 && fth < last) last = fth;
    lat = 3;
    for (int h = 0; h <= last; h++) begin
      if (stall_h >= 0 && h >= stall_h) break;
      if (h == 0 || !mute[h]) begin
        e.h = h;
        e.a = 2'(1 << (h % 2));
        e.b = 3'(1 << (h % 3));
        sb_q.push_back(e);
      end
      if (h > 0) lat += mute[h] ? 3 : 4;
    end
    align_to_period();
    tot_a = $urandom;
    tot_b = {16'($urandom), 32'($urandom)};
    if (stall_h >= 0 && exp_ovr != 8'hFF) exp_ovr = exp_ovr + 8'd1;
    s.ta = tot_a;
    s.tb = tot_b;
    s.ovr = exp_ovr;
    sd_q.push_back(s);
    i_Harmonic_Limit = 8'(limit);
    i_Sample_Ready = 1'b1;
    i_Freq_Too_High = 1'b0;
    i_Comb_Muted = 1'b0;
    i_Enable = 1'b1;
    cyc = 0; restart_at = -1; nclear = 0; nrestart = 0; nsend = 0; nnext = 0; nmstart = 0;
    while (nsend == 0 && cyc < 2 * SI) begin
      @(negedge clk);
      edges++;
      cyc++;
      if (a_busy) i_Enable = 1'b0;
      if (a_next) nnext++;
      if (a_mstart) nmstart++;
      if (a_mrestart) begin
        nrestart++;
        restart_at = cyc;
        nchecks++;
        if (a_harm !== 8'd0) begin
          nerr++;
          $display("FAIL %s restart_harmonic: got %0d, expected 0", name, a_harm);
        end
      end
      if (a_astart != '0 || b_astart != '0) begin
        nchecks++;
        if (sb_q.size() == 0) begin
          nerr++;
          $display("FAIL %s adder_start: unexpected pulse h=%0d a=%b b=%b", name, a_harm, a_astart, b_astart);
        end else begin
          g = sb_q.pop_front();
          if (32'(a_harm) !== g.h || a_astart !== g.a || b_astart !== g.b) begin
            nerr++;
            $display("FAIL %s adder_start: got h=%0d a=%b b=%b, expected h=%0d a=%b b=%b",
                     name, a_harm, a_astart, b_astart, g.h, g.a, g.b);
          end
        end
      end
      if (a_clear) begin
        nclear++;
        if (stall_h < 0 && restart_at > 0) begin
          nchecks++;
          if (cyc - restart_at !== lat) begin
            nerr++;
            $display("FAIL %s frame_latency: got %0d, expected %0d", name, cyc - restart_at, lat);
          end
        end
      end
      if (a_send) begin
        nsend++;
        gs = sd_q.pop_front();
        nchecks++;
        if ((edges % SI) !== 0 || a_busy !== 1'b0) begin
          nerr++;
          $display("FAIL %s dac_send_timing: got edge %0d busy %b, expected tick+1 busy 0", name, edges, a_busy);
        end
        nchecks++;
        if (a_total !== gs.ta || b_total !== gs.tb) begin
          nerr++;
          $display("FAIL %s channel_total: got %h/%h, expected %h/%h", name, a_total, b_total, gs.ta, gs.tb);
        end
        nchecks++;
        if (a_ovr !== gs.ovr) begin
          nerr++;
          $display("FAIL %s overrun_count: got %0d, expected %0d", name, a_ovr, gs.ovr);
        end
      end
      i_Comb_Muted = mute[a_harm[5:0]];
      i_Freq_Too_High = (fth >= 0) && (32'(a_harm) == fth);
      i_Sample_Ready = !((stall_h >= 0) && (32'(a_harm) == stall_h));
    end
    nchecks++;
    if (nsend != 1 || nclear != 1 || nrestart != 1 || sb_q.size() != 0) begin
      nerr++;
      $display("FAIL %s frame_counts: got send=%0d clear=%0d restart=%0d missing_starts=%0d, expected 1/1/1/0",
               name, nsend, nclear, nrestart, sb_q.size());
    end
    if (stall_h < 0) begin
      nchecks++;
      if (nnext != last || nmstart != last) begin
        nerr++;
        $display("FAIL %s next_pulses: got next=%0d mult=%0d, expected %0d", name, nnext, nmstart, last);
      end
    end
    sb_q.delete();
    sd_q.delete();
    i_Sample_Ready = 1'b1;
    i_Freq_Too_High = 1'b0;
    i_Comb_Muted = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++;
    if ({a_harm, a_next, a_mstart, a_mrestart, a_astart, a_clear, a_total, a_send, a_ovr, a_busy} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs_a: got nonzero outputs, expected all 0");
    end
    nchecks++;
    if ({b_harm, b_next, b_mstart, b_mrestart, b_astart, b_clear, b_total, b_send, b_ovr, b_busy} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs_b: got nonzero outputs, expected all 0");
    end
    reset_n = 1'b1;
    edges = 0;
    repeat (3) begin
      @(negedge clk);
      edges++;
    end
    nchecks++;
    if (a_busy !== 1'b0 || a_mrestart !== 1'b0) begin
      nerr++;
      $display("FAIL idle_without_enable: got busy=%b restart=%b, expected 0/0", a_busy, a_mrestart);
    end
  endtask

  task automatic test_basic();
    run_frame("basic_L5", 5, 64'd0, -1, -1);
  endtask

  task automatic test_comb_mute();
    run_frame("comb_mute_L7", 7, 64'h24, -1, -1);
  endtask

  task automatic test_freq_too_high();
    run_frame("freq_too_high", 50, 64'd0, 3, -1);
  endtask

  task automatic test_overrun();
    run_frame("overrun_abort", 10, 64'd0, -1, 2);
    run_frame("after_overrun", 3, 64'd0, -1, -1);
  endtask

  task automatic test_limits();
    run_frame("limit_zero", 0, 64'd0, -1, -1);
    run_frame("limit_200", 200, 64'd0, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 4, 64'h8, -1, -1);
    run_frame("b2b_second", 9, 64'h100, -1, -1);
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    align_to_period();
    i_Harmonic_Limit = 8'd20;
    i_Enable = 1'b1;
    cyc = 0;
    while (a_harm != 8'd10 && cyc < 200) begin
      @(negedge clk);
      edges++;
      cyc++;
      if (a_busy) i_Enable = 1'b0;
    end
    nchecks++;
    if (a_harm !== 8'd10) begin
      nerr++;
      $display("FAIL reach_harmonic_10: got %0d, expected 10", a_harm);
    end
    reset_n = 1'b0;
    #1;
    nchecks++;
    if ({a_harm, a_next, a_mstart, a_mrestart, a_astart, a_clear, a_total, a_send, a_ovr, a_busy} !== '0) begin
      nerr++;
      $display("FAIL midframe_reset_a: got harm=%0d ovr=%0d busy=%b, expected all 0", a_harm, a_ovr, a_busy);
    end
    nchecks++;
    if ({b_harm, b_next, b_mstart, b_mrestart, b_astart, b_clear, b_total, b_send, b_ovr, b_busy} !== '0) begin
      nerr++;
      $display("FAIL midframe_reset_b: got harm=%0d ovr=%0d busy=%b, expected all 0", b_harm, b_ovr, b_busy);
    end
    exp_ovr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    edges = 0;
    run_frame("after_reset", 6, 64'd0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_comb_mute();
    test_freq_too_high();
    test_overrun();
    test_limits();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire
